mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, 16-bit, byte-addressed, combinational-read memory between the instruction-fetch port and the data load/store port of the core. Each cycle it grants at most one requester and drives the memory enable, write, address and data lines. It registers read data for a one-cycle-later response and flags misaligned accesses. Data accesses have priority, and a bounded-wait counter keeps the fetch port from starving.

## Interface
- DWIDTH, 16, data width of memory and both ports
- AWIDTH, 16, byte-address width
- STARVE_LIMIT, 4, consecutive fetch denials after which fetch wins the next contested cycle (range 1..15)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  AWIDTH  fetch byte address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid (one cycle after if_gnt)
- if_rdata  out  DWIDTH  registered fetch data
- if_err  out  1  with if_rvalid: request was misaligned
- dm_req  in  1  data request, held until dm_gnt
- dm_wr  in  1  1 = store, 0 = load
- dm_addr  in  AWIDTH  data byte address
- dm_wdata  in  DWIDTH  store data
- dm_gnt  out  1  data request accepted this cycle (combinational)
- dm_rvalid  out  1  response valid one cycle after dm_gnt (loads and stores)
- dm_rdata  out  DWIDTH  registered load data (0 for stores)
- dm_err  out  1  with dm_rvalid: request was misaligned
- mem_enable  out  1  to memory enable
- mem_wr  out  1  to memory write
- mem_addr  out  AWIDTH  to memory address
- mem_wdata  out  DWIDTH  to memory data_in
- mem_rdata  in  DWIDTH  from memory data_out

## Operation
- Arbitration is combinational on the current requests.
  - Only one port requests: that port is granted.
  - Both request: dm wins, unless starve_cnt == STARVE_LIMIT, in which case if wins.
- starve_cnt (4 bits):
  - +1 each cycle if_req=1 and if_gnt=0, saturating at STARVE_LIMIT.
  - Cleared on any if_gnt or when if_req=0.
- Misalignment: a granted request with addr[0]=1 still gets a gnt and a response with err=1 and rdata=0. The memory is not enabled (mem_enable=0), so a misaligned store never writes.
- Memory drive when a grant is aligned:
  - mem_enable=1, mem_addr = granted addr.
  - mem_wr = dm_wr for dm, 0 for if.
  - mem_wdata = dm_wdata.
- Memory drive otherwise: all mem_* outputs are 0.
- Read data capture: on a grant, mem_rdata is registered into the winner's rdata. The loser's rdata holds its previous value.
- For dm stores, dm_rdata is registered as 0.
- rvalid is set for exactly one cycle after a grant to that port.
- The two rvalids can never be high together.
- Back-to-back grants to the same port give rvalid on consecutive cycles.

## Timing
- Grant latency: 0 cycles; gnt is asserted in the same cycle the request is seen.
- Response latency: 1 cycle; rvalid/rdata/err are valid in the cycle after gnt.
- Throughput: one access per cycle, total across both ports.
- Starvation bound: with both ports requesting continuously, fetch is granted once every STARVE_LIMIT+1 cycles.
- Reset (rst=1), checked at each rising edge:
  - Outputs: mem_enable=0, mem_wr=0, if_gnt=0, dm_gnt=0.
  - Registers cleared: starve_cnt=0, if_rvalid=0, dm_rvalid=0, if_rdata=0, dm_rdata=0, if_err=0, dm_err=0.
  - Because mem_enable=0 during reset, no access reaches the memory while it loads its image.
- Reset mid-operation: a response due in the next cycle is dropped (rvalid stays 0). Requesters must re-issue the request.
- Requests arriving in the first cycle after rst falls are arbitrated normally.

## Structure
- Shared package mem_arb_pkg holds:
  - PORT_IF=0 and PORT_DM=1.
  - The default STARVE_LIMIT.
  - The starve_cnt width (4).
- Natural sub-module: arb_starve_counter, a saturating counter with inc, clr and limit-reached outputs.
- All other logic stays inline: grant mux and the two response registers.

## Test plan
- Reset: hold rst=1 for 2 cycles with if_req=dm_req=1 -> no gnt, mem_enable=0 throughout, all rvalid=0.
- Single fetch: memory word at byte addr 0x0004 = 0xBEEF; if_req with if_addr=0x0004 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0xBEEF, if_err=0.
- Store then load:
  - dm store 0x1234 to 0x0010 -> mem_wr=1 for one cycle.
  - Following load from 0x0010 -> dm_rdata=0x1234 one cycle after its dm_gnt.
- Contention, STARVE_LIMIT=4: both ports request continuously for 12 cycles -> grant pattern dm,dm,dm,dm,if,dm,dm,dm,dm,if,dm,dm.
- Misaligned store: dm_req, dm_wr=1, dm_addr=0x0011 -> dm_gnt=1 with mem_enable=0; next cycle dm_rvalid=1, dm_err=1, dm_rdata=0; word at 0x0010 is unchanged.
- Reset mid-access: assert rst in the cycle of an if_gnt -> if_rvalid=0 in the next cycle and starve_cnt=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   PORT_IF / PORT_DM : port identifiers used for the grant winner
//   STARVE_LIMIT_DEF  : default fetch starvation bound
//   STARVE_W          : width of the fetch starvation counter
package mem_arb_pkg;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned STARVE_W         = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive fetch denials.
//   clk, rst     : clock, synchronous active-high reset
//   inc          : fetch requested but not granted this cycle
//   clr          : fetch granted or not requesting this cycle
//   cnt          : current denial count
//   limit_hit_c  : cnt has reached LIMIT (fetch wins next contest)
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                clr,
  output logic [STARVE_W-1:0] cnt,
  output logic                limit_hit_c
);

  assign limit_hit_c = (cnt == STARVE_W'(LIMIT));

  // Clear has priority over increment; saturate at LIMIT.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !limit_hit_c) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port combinational-read memory between the fetch (if)
// and data (dm) ports. Data wins contention unless fetch has been denied
// STARVE_LIMIT times in a row. Responses are registered one cycle after grant;
// misaligned (odd byte address) accesses are granted but never reach memory.
//   clk, rst                                : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt                : fetch request, combinational grant
//   if_rvalid/if_rdata/if_err               : registered fetch response
//   dm_req/dm_wr/dm_addr/dm_wdata -> dm_gnt : data request, combinational grant
//   dm_rvalid/dm_rdata/dm_err               : registered data response
//   mem_enable/mem_wr/mem_addr/mem_wdata    : memory drive
//   mem_rdata                               : memory combinational read data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DWIDTH       = 16,
  parameter int unsigned AWIDTH       = 16,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DWIDTH-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [AWIDTH-1:0] dm_addr,
  input  logic [DWIDTH-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DWIDTH-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  port_e               winner;
  logic                gnt_any;
  logic                aligned;
  logic [AWIDTH-1:0]   gnt_addr;
  logic                limit_hit;
  logic [STARVE_W-1:0] starve_cnt;

  // Winner selection; only meaningful when gnt_any is set.
  always_comb begin
    winner = PORT_DM;
    if (if_req && (!dm_req || limit_hit)) begin
      winner = PORT_IF;
    end
  end

  assign gnt_any  = !rst && (if_req || dm_req);
  assign if_gnt   = gnt_any && (winner == PORT_IF);
  assign dm_gnt   = gnt_any && (winner == PORT_DM);
  assign gnt_addr = (winner == PORT_IF) ? if_addr : dm_addr;
  assign aligned  = gnt_any && !gnt_addr[0];

  // Memory sees only aligned grants; everything is zero otherwise.
  assign mem_enable = aligned;
  assign mem_wr     = aligned && dm_gnt && dm_wr;
  assign mem_addr   = aligned ? gnt_addr : '0;
  assign mem_wdata  = aligned ? dm_wdata : '0;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .inc        (if_req && !if_gnt),
    .clr        (if_gnt || !if_req),
    .cnt        (starve_cnt),
    .limit_hit_c(limit_hit)
  );

  // Response registers; a port's rdata holds while it is not granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      dm_rvalid <= 1'b0;
      dm_err    <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= if_gnt;
      if_err    <= if_gnt && if_addr[0];
      dm_rvalid <= dm_gnt;
      dm_err    <= dm_gnt && dm_addr[0];
      if (if_gnt) begin
        if_rdata <= if_addr[0] ? '0 : mem_rdata;
      end
      if (dm_gnt) begin
        dm_rdata <= (dm_addr[0] || dm_wr) ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural memory and a
// response scoreboard checked by a negedge monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [15:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [15:0] dm_rdata;
  logic        dm_err;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  typedef struct packed {
    logic        port;
    logic [15:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .dm_req    (dm_req),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .dm_err    (dm_err),
    .mem_enable(mem_enable),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Behavioural memory: unwritten words return a fixed image.
  logic [15:0] mem     [0:255];
  bit          written [0:255];

  function automatic logic [15:0] image_word(input logic [7:0] idx);
    return (idx == 8'd2) ? 16'hBEEF : (16'hA000 | {8'h00, idx});
  endfunction

  assign mem_rdata = written[mem_addr[8:1]] ? mem[mem_addr[8:1]] : image_word(mem_addr[8:1]);

  always @(posedge clk) begin
    if (mem_enable && mem_wr) begin
      mem[mem_addr[8:1]]     <= mem_wdata;
      written[mem_addr[8:1]] <= 1'b1;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    rsp_t e;
    rsp_t o;
    if (if_rvalid === 1'b1 && dm_rvalid === 1'b1) begin
      n_checks++;
      $display("FAIL rvalid_exclusive: got if_rvalid=1 dm_rvalid=1 required at most one");
    end
    if (if_rvalid === 1'b1 || dm_rvalid === 1'b1) begin
      n_checks++;
      o.port  = (if_rvalid === 1'b1) ? 1'b0 : 1'b1;
      o.rdata = o.port ? dm_rdata : if_rdata;
      o.err   = o.port ? dm_err : if_err;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_rsp: got port=%0d rdata=%h err=%b required none", o.port, o.rdata, o.err);
      end else begin
        e = sb.pop_front();
        if (o !== e) begin
          $display("FAIL response: got port=%0d rdata=%h err=%b required port=%0d rdata=%h err=%b",
                   o.port, o.rdata, o.err, e.port, e.rdata, e.err);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (sb.size() !== 0) $display("FAIL %s_drained: got %0d pending responses required 0", name, sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_wr = 1'b1;
    if_addr = 16'h0004; dm_addr = 16'h0010; dm_wdata = 16'h5555;
    repeat (2) begin
      tick(); #1;
      n_checks++;
      if ({if_gnt, dm_gnt, mem_enable, mem_wr} !== 4'b0000)
        $display("FAIL reset_outputs: got %b required 0000", {if_gnt, dm_gnt, mem_enable, mem_wr});
      else n_pass++;
      n_checks++;
      if ({if_rvalid, dm_rvalid, if_err, dm_err, if_rdata, dm_rdata, dut.starve_cnt} !== 40'h0)
        $display("FAIL reset_regs: got %h required 0",
                 {if_rvalid, dm_rvalid, if_err, dm_err, if_rdata, dm_rdata, dut.starve_cnt});
      else n_pass++;
    end
    tick();
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    tick();
    check_drained("reset");
  endtask

  task automatic test_single_fetch();
    tick();
    if_req = 1'b1; if_addr = 16'h0004; #1;
    n_checks++;
    if ({if_gnt, dm_gnt, mem_enable, mem_wr, mem_addr} !== {4'b1010, 16'h0004})
      $display("FAIL fetch_grant: got %h required %h", {if_gnt, dm_gnt, mem_enable, mem_wr, mem_addr}, {4'b1010, 16'h0004});
    else n_pass++;
    sb.push_back(rsp_t'{port: 1'b0, rdata: 16'hBEEF, err: 1'b0});
    tick();
    if_req = 1'b0; #1;
    n_checks++;
    if ({mem_enable, mem_addr} !== 17'h0)
      $display("FAIL idle_mem: got %h required 0", {mem_enable, mem_addr});
    else n_pass++;
    tick();
    check_drained("single_fetch");
  endtask

  task automatic test_store_load();
    tick();
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0010; dm_wdata = 16'h1234; #1;
    n_checks++;
    if ({dm_gnt, mem_enable, mem_wr, mem_addr, mem_wdata} !== {3'b111, 16'h0010, 16'h1234})
      $display("FAIL store_drive: got %h required %h", {dm_gnt, mem_enable, mem_wr, mem_addr, mem_wdata},
               {3'b111, 16'h0010, 16'h1234});
    else n_pass++;
    sb.push_back(rsp_t'{port: 1'b1, rdata: 16'h0000, err: 1'b0});
    tick();
    dm_wr = 1'b0; dm_wdata = 16'h0000; #1;
    n_checks++;
    if ({dm_gnt, mem_enable, mem_wr} !== 3'b110)
      $display("FAIL load_drive: got %b required 110", {dm_gnt, mem_enable, mem_wr});
    else n_pass++;
    sb.push_back(rsp_t'{port: 1'b1, rdata: 16'h1234, err: 1'b0});
    tick();
    dm_req = 1'b0; #1;
    n_checks++;
    if (mem_wr !== 1'b0) $display("FAIL store_one_cycle: got mem_wr=%b required 0", mem_wr);
    else n_pass++;
    tick();
    check_drained("store_load");
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [3];
    exp[0] = 16'hA000; exp[1] = 16'hA001; exp[2] = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      if_req = 1'b1; if_addr = 16'(2 * i); #1;
      n_checks++;
      if (if_gnt !== 1'b1) $display("FAIL b2b_grant%0d: got %b required 1", i, if_gnt);
      else n_pass++;
      sb.push_back(rsp_t'{port: 1'b0, rdata: exp[i], err: 1'b0});
    end
    tick();
    if_req = 1'b0; #1;
    n_checks++;
    if ({dm_rvalid, dm_rdata} !== {1'b0, 16'h1234})
      $display("FAIL dm_rdata_hold: got %h required %h", {dm_rvalid, dm_rdata}, {1'b0, 16'h1234});
    else n_pass++;
    tick();
    check_drained("back_to_back");
  endtask

  task automatic test_contention();
    logic [11:0] pat;
    logic        exp_if;
    pat = 12'b0010_0001_0000;
    if_addr = 16'h0020; dm_addr = 16'h0030; dm_wr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if_req = 1'b1; dm_req = 1'b1; #1;
      exp_if = pat[i];
      n_checks++;
      if ({if_gnt, dm_gnt, mem_addr} !== {exp_if, !exp_if, exp_if ? 16'h0020 : 16'h0030})
        $display("FAIL contention%0d: got if_gnt=%b dm_gnt=%b addr=%h required if_gnt=%b dm_gnt=%b",
                 i, if_gnt, dm_gnt, mem_addr, exp_if, !exp_if);
      else n_pass++;
      if (exp_if) sb.push_back(rsp_t'{port: 1'b0, rdata: 16'hA010, err: 1'b0});
      else        sb.push_back(rsp_t'{port: 1'b1, rdata: 16'hA018, err: 1'b0});
    end
    tick();
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    check_drained("contention");
  endtask

  task automatic test_misaligned();
    tick();
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0011; dm_wdata = 16'hDEAD; #1;
    n_checks++;
    if ({dm_gnt, mem_enable, mem_wr, mem_addr, mem_wdata} !== {3'b100, 32'h0})
      $display("FAIL misaligned_store_drive: got %h required %h",
               {dm_gnt, mem_enable, mem_wr, mem_addr, mem_wdata}, {3'b100, 32'h0});
    else n_pass++;
    sb.push_back(rsp_t'{port: 1'b1, rdata: 16'h0000, err: 1'b1});
    tick();
    dm_req = 1'b0; dm_wr = 1'b0; if_req = 1'b1; if_addr = 16'h0005; #1;
    n_checks++;
    if ({if_gnt, mem_enable} !== 2'b10)
      $display("FAIL misaligned_fetch_drive: got %b required 10", {if_gnt, mem_enable});
    else n_pass++;
    sb.push_back(rsp_t'{port: 1'b0, rdata: 16'h0000, err: 1'b1});
    tick();
    if_req = 1'b0;
    tick();
    n_checks++;
    if (mem[8] !== 16'h1234) $display("FAIL word_0x10_unchanged: got %h required 1234", mem[8]);
    else n_pass++;
    check_drained("misaligned");
  endtask

  task automatic test_reset_mid();
    if_addr = 16'h0020; dm_addr = 16'h0030; dm_wr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if_req = 1'b1; dm_req = 1'b1; #1;
      n_checks++;
      if (dm_gnt !== 1'b1) $display("FAIL pre_reset_grant%0d: got %b required 1", i, dm_gnt);
      else n_pass++;
      sb.push_back(rsp_t'{port: 1'b1, rdata: 16'hA018, err: 1'b0});
    end
    tick();
    rst = 1'b1; #1;
    n_checks++;
    if ({if_gnt, dm_gnt, dut.starve_cnt} !== {2'b00, 4'd2})
      $display("FAIL reset_cycle: got %h required %h", {if_gnt, dm_gnt, dut.starve_cnt}, {2'b00, 4'd2});
    else n_pass++;
    tick();
    n_checks++;
    if ({if_rvalid, dm_rvalid, dut.starve_cnt} !== 6'h0)
      $display("FAIL after_reset: got %h required 0", {if_rvalid, dm_rvalid, dut.starve_cnt});
    else n_pass++;
    rst = 1'b0; dm_req = 1'b0; if_req = 1'b1; if_addr = 16'h0004; #1;
    n_checks++;
    if (if_gnt !== 1'b1) $display("FAIL first_cycle_after_reset: got if_gnt=%b required 1", if_gnt);
    else n_pass++;
    sb.push_back(rsp_t'{port: 1'b0, rdata: 16'hBEEF, err: 1'b0});
    tick();
    n_checks++;
    if (if_gnt !== 1'b1) $display("FAIL grant_before_reset: got if_gnt=%b required 1", if_gnt);
    else n_pass++;
    #1 rst = 1'b1;
    tick();
    n_checks++;
    if ({if_rvalid, dut.starve_cnt} !== 5'h0)
      $display("FAIL dropped_response: got %h required 0", {if_rvalid, dut.starve_cnt});
    else n_pass++;
    rst = 1'b0; if_req = 1'b0;
    tick();
    tick();
    check_drained("reset_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_back_to_back();
    test_contention();
    test_misaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
